// File: rtl/demux9_reg.sv
// -----------------------------------------------------------------------------
// demux9_reg
//   Registered 1-to-9 demultiplexer. One WIDTH-bit source word is written into
//   one of nine holding registers chosen by a 4-bit slot code (0..8). Each slot
//   carries a valid flag that the consumer clears with its clr bit. Codes 9..15
//   are illegal: they change no slot and set a sticky error flag.
//
//   Optional feature (macro DEMUX9_OVERRUN_EN): adds a sticky per-slot overrun
//   flag, set when a legal write lands on a slot that is still valid and is
//   not being cleared in the same cycle.
//
// Ports
//   i_clk       rising-edge clock
//   i_reset     asynchronous, active-high reset; clears all state
//   i_wr_en     write strobe
//   i_sel       destination slot code, 0..8 legal
//   i_data_in   word to store
//   i_clr       per-slot consume strobe; bit k clears valid[k]
//   o_data_out  slot k held word at [k*WIDTH +: WIDTH]
//   o_valid     bit k = slot k holds an unconsumed word
//   o_sel_err   sticky: an illegal code was written
//   o_overrun   sticky per slot overwrite flag (DEMUX9_OVERRUN_EN only)
// -----------------------------------------------------------------------------
module demux9_reg #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [3:0]         i_sel,
  input  logic [WIDTH-1:0]   i_data_in,
  input  logic [8:0]         i_clr,
  output logic [9*WIDTH-1:0] o_data_out,
  output logic [8:0]         o_valid,
  output logic               o_sel_err
`ifdef DEMUX9_OVERRUN_EN
  ,
  output logic [8:0]         o_overrun
`endif
);

  logic [8:0][WIDTH-1:0] r_data;
  logic [8:0]            r_valid;
  logic                  r_sel_err;
  logic                  w_legal;
  logic [8:0]            w_wr_hot;   // one-hot write target, zero when no legal write

  // NOTE: every signal driven from always_comb gets a default on entry, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_legal  = (i_sel <= 4'd8);
    w_wr_hot = '0;
    if (i_wr_en && w_legal)
      w_wr_hot = 9'b1 << i_sel;
  end

  // NOTE: the data registers are reset as well as the flags, because data_out
  // is architecturally visible and must read zero after reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= '0;
      r_sel_err <= 1'b0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        // Write beats a same-cycle clear: the old word counts as consumed.
        if (w_wr_hot[k]) begin
          r_data[k]  <= i_data_in;
          r_valid[k] <= 1'b1;
        end else if (i_clr[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (i_wr_en && !w_legal)
        r_sel_err <= 1'b1;
    end
  end

`ifdef DEMUX9_OVERRUN_EN
  logic [8:0] r_overrun;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_overrun <= '0;
    else
      r_overrun <= r_overrun | (w_wr_hot & r_valid & ~i_clr);
  end

  assign o_overrun = r_overrun;
`endif

  assign o_data_out = r_data;
  assign o_valid    = r_valid;
  assign o_sel_err  = r_sel_err;

endmodule

// File: doc/demux9_reg.md
# demux9_reg

Registered 1-to-9 demultiplexer: steers one WIDTH-bit source word into one of nine holding registers selected by a 4-bit code. Each slot carries a valid flag that is cleared by its consumer. It is the write-side counterpart of the datapath's 9-input select muxes, routing one producer (e.g. ALU or memory result) to multiple downstream destinations instead of choosing among multiple sources. Code 0000 selects slot 0, and so on up to 1000 for slot 8. Codes 1001–1111 are illegal.

## Interface
- WIDTH, 32, data word width in bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- wr_en  input  1  write strobe; sampled on rising clk.
- sel  input  4  destination slot code, 0..8 legal.
- data_in  input  WIDTH  word to store.
- clr  input  9  per-slot consume strobe; bit k clears valid[k].
- data_out  output  9*WIDTH  slot k held word at [k*WIDTH +: WIDTH].
- valid  output  9  bit k = slot k holds an unconsumed word.
- sel_err  output  1  sticky: an illegal sel was written.
- overrun  output  9  sticky per slot: a write landed on a still-valid slot. Exists only with DEMUX9_OVERRUN_EN.

## Operation
- Write, wr_en=1 and sel≤8:
  - slot[sel] ← data_in and valid[sel] ← 1 on the next rising clk.
  - All other slots hold.
- Illegal write, wr_en=1 and sel≥9:
  - No slot or valid bit changes.
  - sel_err ← 1 and stays set until reset.
- Consume, clr[k]=1: valid[k] ← 0 on the next clk. data_out for slot k is retained, not zeroed.
- Write and clr to the same slot in the same cycle: the write wins.
  - valid stays 1 and the data updates.
  - No overrun is flagged, because the old word counts as consumed.
- Write to slot j with clr[k], j≠k, in the same cycle: both take effect independently.
- clr is a level sampled each cycle:
  - Multiple clr bits may be set at once.
  - clr on an already-invalid slot has no effect.
- wr_en=0: sel and data_in are don't-care. No state changes apart from clr.
- No backpressure: a write is always accepted. Producers must check valid[sel] themselves if loss is unacceptable.

## Timing
- Reset (asynchronous, reset=1): data_out=0 for all slots, valid=9'b0, sel_err=0, overrun=9'b0. The block holds these values while reset is asserted.
- Reset deassertion: the first write is accepted on the first rising clk after deassertion.
- Reset mid-operation: all slots are invalidated immediately, without waiting for clk. Any same-cycle write is lost.
- Write latency: 1 cycle. data_out and valid reflect the write after the edge on which wr_en was sampled.
- Clear latency: 1 cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Throughput: one write per cycle, to any slot, including back-to-back writes to the same slot.

## Configuration
- DEMUX9_OVERRUN_EN defined:
  - Adds the overrun[8:0] port and logic.
  - overrun[k] ← 1 when a legal write targets slot k while valid[k]=1 and clr[k]=0.
  - The bit is sticky until reset.
  - The write itself still occurs and overwrites the old word.
- DEMUX9_OVERRUN_EN undefined:
  - The overrun port and its flops are absent.
  - Overwrites are silent.
  - All other behaviour is identical.

## Test plan
- Reset, then sweep writes:
  - Stimulus: assert reset; release; write data_in=32'hA0+k with sel=k for k=0..8 on consecutive cycles.
  - Response: after each edge, slot k=32'hA0+k and valid[k] sets one cycle after its write. Finally valid=9'h1FF and sel_err=0.
- Illegal select:
  - Stimulus: wr_en=1, sel=4'b1001, data_in=32'hDEADBEEF.
  - Response: no slot or valid bit changes; sel_err=1 next cycle and stays 1 through later legal writes.
- Write/clear collision:
  - Stimulus: slot 3 valid holding 32'h1111; same cycle wr_en=1, sel=3, data_in=32'h2222, clr=9'h008.
  - Response: slot 3=32'h2222, valid[3]=1, overrun[3]=0.
- Overrun (DEMUX9_OVERRUN_EN defined):
  - Stimulus: write slot 5 twice with no clr.
  - Response: after the second edge, overrun=9'h020 and slot 5 holds the second word.
  - Build without the macro: same sequence compiles and only the data updates.
- Async reset mid-stream:
  - Stimulus: alternate writes and clears; assert reset between clock edges.
  - Response: valid=0, all data_out=0 and sel_err=0 immediately, without waiting for clk. A write sampled at the first edge after release lands correctly.
